pipe_hazard_ctrl: RTL

- Parametrised hazard/pipeline-control unit for the five-stage Y86 pipeline; drives the stall/bubble controls of the F, D, E, M and W pipeline registers.
- Generalises the basic mispredict / load-use / ret logic:
  - configurable register-ID width and source-operand count;
  - counter-tracked ret window;
  - multi-cycle execute-op freeze;
  - sticky halt/exception freeze.

---
 rtl/pipe_hazard_ctrl_pkg.sv | 22 ++
 rtl/pipe_hazard_ctrl_if.sv | 24 ++
 rtl/pipe_hazard_ctrl_haz_detect.sv | 28 ++
 rtl/pipe_hazard_ctrl.sv | 117 +++++++++++
 4 files changed

// File: rtl/pipe_hazard_ctrl_pkg.sv
// pipe_ctrl_pkg: shared Y86 icodes, register/status codes and control FSM states.
package pipe_ctrl_pkg;
  localparam logic [3:0] I_HALT   = 4'h0;
  localparam logic [3:0] I_NOP    = 4'h1;
  localparam logic [3:0] I_RRMOVL = 4'h2;
  localparam logic [3:0] I_IRMOVL = 4'h3;
  localparam logic [3:0] I_RMMOVL = 4'h4;
  localparam logic [3:0] I_MRMOVL = 4'h5;
  localparam logic [3:0] I_OPL    = 4'h6;
  localparam logic [3:0] I_JXX    = 4'h7;
  localparam logic [3:0] I_CALL   = 4'h8;
  localparam logic [3:0] I_RET    = 4'h9;
  localparam logic [3:0] I_PUSHL  = 4'hA;
  localparam logic [3:0] I_POPL   = 4'hB;
  localparam logic [3:0] I_MC     = 4'hC;
  localparam logic [3:0] RNONE    = 4'hF;
  localparam logic [2:0] S_AOK    = 3'd1;
  localparam logic [2:0] S_HLT    = 3'd2;
  localparam logic [2:0] S_ADR    = 3'd3;
  localparam logic [2:0] S_INS    = 3'd4;
  typedef enum logic [1:0] {RUN = 2'd0, RET_WAIT = 2'd1, MC_BUSY = 2'd2, HALTED = 2'd3} ctrl_state_t;
endpackage

// File: rtl/pipe_hazard_ctrl_if.sv
// pipe_hazard_ctrl_if: pipeline status in, stage stall/bubble controls out.
interface pipe_hazard_ctrl_if #(
  parameter int ICODE_W = 4,
  parameter int REG_W   = 4,
  parameter int NUM_SRC = 2,
  parameter int STAT_W  = 3
);
  logic [ICODE_W-1:0]       D_icode, E_icode, M_icode;
  logic [REG_W-1:0]         E_dstM;
  logic [NUM_SRC*REG_W-1:0] d_src;
  logic                     e_cnd;
  logic [STAT_W-1:0]        m_stat, W_stat;
  logic                     F_stall, D_stall, D_bubble, E_stall, E_bubble, M_bubble, W_stall;
  logic                     set_cc_dis, halted;
  logic [1:0]               ctrl_state;
  modport master (
    output D_icode, E_icode, M_icode, E_dstM, d_src, e_cnd, m_stat, W_stat,
    input  F_stall, D_stall, D_bubble, E_stall, E_bubble, M_bubble, W_stall, set_cc_dis, halted, ctrl_state
  );
  modport slave (
    input  D_icode, E_icode, M_icode, E_dstM, d_src, e_cnd, m_stat, W_stat,
    output F_stall, D_stall, D_bubble, E_stall, E_bubble, M_bubble, W_stall, set_cc_dis, halted, ctrl_state
  );
endinterface

// File: rtl/pipe_hazard_ctrl_haz_detect.sv
// haz_detect: combinational mispredict, load-use and exception terms.
module haz_detect
  import pipe_ctrl_pkg::*;
#(
  parameter int ICODE_W = 4,
  parameter int REG_W   = 4,
  parameter int NUM_SRC = 2,
  parameter int STAT_W  = 3
) (
  input  logic [ICODE_W-1:0]       E_icode,
  input  logic [REG_W-1:0]         E_dstM,
  input  logic [NUM_SRC*REG_W-1:0] d_src,
  input  logic                     e_cnd,
  input  logic [STAT_W-1:0]        m_stat,
  input  logic [STAT_W-1:0]        W_stat,
  output logic                     mispredict,
  output logic                     load_use,
  output logic                     except
);
  logic [NUM_SRC-1:0] hit;
  for (genvar i = 0; i < NUM_SRC; i++) begin : g_src
    assign hit[i] = d_src[i*REG_W +: REG_W] == E_dstM;
  end
  assign mispredict = E_icode == ICODE_W'(I_JXX) && !e_cnd;
  assign load_use   = (E_icode == ICODE_W'(I_MRMOVL) || E_icode == ICODE_W'(I_POPL)) &&
                      E_dstM != {REG_W{1'b1}} && |hit;
  assign except     = m_stat != STAT_W'(S_AOK) || W_stat != STAT_W'(S_AOK);
endmodule

// File: rtl/pipe_hazard_ctrl.sv
// pipe_hazard_ctrl: Y86 pipeline hazard FSM and stall/bubble priority mux.
// HAZ_PERF_CNT_EN adds saturating mispredict/load-use/ret-stall counters.
module pipe_hazard_ctrl
  import pipe_ctrl_pkg::*;
#(
  parameter int                 ICODE_W   = 4,
  parameter int                 REG_W     = 4,
  parameter int                 NUM_SRC   = 2,
  parameter int                 STAT_W    = 3,
  parameter int                 RET_DEPTH = 3,
  parameter logic [ICODE_W-1:0] MC_ICODE  = 4'hC,
  parameter int                 MC_LAT    = 4
) (
  input  logic               clk,
  input  logic               rst_n,
  pipe_hazard_ctrl_if.slave  hif
`ifdef HAZ_PERF_CNT_EN
  ,
  output logic [15:0]        perf_mispredict,
  output logic [15:0]        perf_load_use,
  output logic [15:0]        perf_ret_stall
`endif
);
  ctrl_state_t state, state_nxt;
  logic [2:0] ret_cnt, ret_nxt;
  logic [3:0] mc_cnt, mc_nxt;
  logic mis, lu, exc, w_bad, d_ret, mc_go;
  logic f_s, d_s, d_b, e_s, e_b, m_b, w_s, hlt;
  haz_detect #(.ICODE_W(ICODE_W), .REG_W(REG_W), .NUM_SRC(NUM_SRC), .STAT_W(STAT_W)) u_haz (
    .E_icode(hif.E_icode), .E_dstM(hif.E_dstM), .d_src(hif.d_src), .e_cnd(hif.e_cnd),
    .m_stat(hif.m_stat), .W_stat(hif.W_stat), .mispredict(mis), .load_use(lu), .except(exc)
  );
  assign w_bad = hif.W_stat != STAT_W'(S_AOK);
  assign d_ret = hif.D_icode == ICODE_W'(I_RET);
  assign mc_go = MC_LAT > 1 && hif.E_icode == MC_ICODE && (state == RUN || state == RET_WAIT);
  always_comb begin
    {f_s, d_s, d_b, e_s, e_b, m_b, w_s, hlt} = '0;
    state_nxt = state;
    ret_nxt   = ret_cnt;
    mc_nxt    = mc_cnt;
    if (state == HALTED || w_bad) begin
      {f_s, d_s, e_s, w_s, m_b, hlt} = '1;
      state_nxt = HALTED;
    end else if (state == MC_BUSY) begin
      {f_s, d_s, e_s, m_b} = '1;
      mc_nxt = mc_cnt - 4'd1;
      // a ret window interrupted by the op resumes where it left off
      if (mc_cnt == 4'd1) state_nxt = ret_cnt != 3'd0 ? RET_WAIT : RUN;
    end else begin
      if (mis) begin
        {d_b, e_b} = '1;
        ret_nxt   = 3'd0;
        state_nxt = RUN;
      end else if (lu) begin
        {f_s, d_s, e_b} = '1;
        if (state == RET_WAIT) begin
          ret_nxt = ret_cnt - 3'd1;
          if (ret_cnt == 3'd1) state_nxt = RUN;
        end
      end else if (state == RET_WAIT) begin
        {f_s, d_b} = '1;
        ret_nxt = ret_cnt - 3'd1;
        if (ret_cnt == 3'd1) state_nxt = RUN;
      end else if (d_ret) begin
        {f_s, d_b} = '1;
        ret_nxt   = 3'(RET_DEPTH - 1);
        state_nxt = RET_DEPTH > 1 ? RET_WAIT : RUN;
      end
      if (mc_go) begin
        state_nxt = MC_BUSY;
        mc_nxt    = 4'(MC_LAT - 1);
      end
    end
  end
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state   <= RUN;
      ret_cnt <= 3'd0;
      mc_cnt  <= 4'd0;
    end else begin
      state   <= state_nxt;
      ret_cnt <= ret_nxt;
      mc_cnt  <= mc_nxt;
    end
  end
  // outputs are forced low while reset is held, whatever the inputs do
  assign hif.F_stall    = rst_n & f_s;
  assign hif.D_stall    = rst_n & d_s;
  assign hif.D_bubble   = rst_n & d_b;
  assign hif.E_stall    = rst_n & e_s;
  assign hif.E_bubble   = rst_n & e_b;
  assign hif.M_bubble   = rst_n & (m_b | exc);
  assign hif.W_stall    = rst_n & w_s;
  assign hif.set_cc_dis = rst_n & exc;
  assign hif.halted     = rst_n & hlt;
  assign hif.ctrl_state = state;
  assert property (@(posedge clk) disable iff (!rst_n)
    !(hif.D_stall && hif.D_bubble) && !(hif.E_stall && hif.E_bubble));
`ifdef HAZ_PERF_CNT_EN
  logic free, r_mis, r_lu, r_ret;
  assign free  = !w_bad && (state == RUN || state == RET_WAIT);
  assign r_mis = free && mis;
  assign r_lu  = free && !mis && lu;
  assign r_ret = free && !mis && !lu && (state == RET_WAIT || d_ret);
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      perf_mispredict <= '0;
      perf_load_use   <= '0;
      perf_ret_stall  <= '0;
    end else begin
      perf_mispredict <= perf_mispredict + 16'(r_mis && perf_mispredict != 16'hFFFF);
      perf_load_use   <= perf_load_use + 16'(r_lu && perf_load_use != 16'hFFFF);
      perf_ret_stall  <= perf_ret_stall + 16'(r_ret && perf_ret_stall != 16'hFFFF);
    end
  end
`endif
endmodule
